uart_rx_param: RTL and testbench

//  Parametrised UART receive engine, the successor to the fixed 8-bit receiver.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param_baud_tick.sv | 40 ++++
 rtl/uart_rx_param.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, legal ranges and parity helper for the UART receiver
package uart_pkg;

  localparam int DATA_W_MIN     = 5;
  localparam int DATA_W_MAX     = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

  // Expected parity bit; callers zero-extend data, which leaves the XOR unchanged.
  function automatic logic par_calc(input logic [DATA_W_MAX-1:0] data, input parity_e mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic has_parity(input parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-word handshake between the UART receiver and the host
interface uart_rx_param_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_out;
  logic              data_ready;
  logic              data_ack;
  logic              parity_error;
  logic              stop_error;
  logic              overrun;

  modport master (
    output data_out, data_ready, parity_error, stop_error, overrun,
    input  data_ack
  );

  modport slave (
    input  data_out, data_ready, parity_error, stop_error, overrun,
    output data_ack
  );

endinterface

// File: rtl/uart_rx_param_baud_tick.sv
// rtl/uart_rx_param_baud_tick.sv - uart_baud_tick: one-clk tick every baud_div+1 clks, restartable
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  // The divisor is captured only at reload so a mid-period change never truncates a tick.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    div_d = div_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
      div_d = baud_div;
    end else if (cnt_q == div_q) begin
      tick  = 1'b1;
      cnt_d = '0;
      div_d = baud_div;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receive engine; UART_RX_MAJORITY_VOTE_EN selects 2-of-3 bit voting
import uart_pkg::*;

module uart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_en,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  output logic             busy,
  uart_rx_param_if.master  rx_if
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_rx_param: DATA_W out of range");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_param: OVERSAMPLE must be even and in range");
  end

  localparam int CNT_W = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MID_CNT = OVERSAMPLE / 2;
`else
  localparam int MID_CNT = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(MID_CNT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  parity_e           par_mode_q, par_mode_d;
  logic              two_stop_q, two_stop_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_err_q, par_err_d;
  logic              stop_err_q, stop_err_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_ready_q, data_ready_d;
  logic              parity_error_q, parity_error_d;
  logic              stop_error_q, stop_error_d;
  logic              overrun_q, overrun_d;

  logic                  tick, restart, bit_val, fall, frame_done, ack;
  logic [DATA_W_MAX-1:0] par_in;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .baud_div (baud_div),
    .tick     (tick)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision point is one tick late so the window covers ticks mid-1, mid, mid+1.
  logic [1:0] maj_q, maj_d;
  always_comb begin
    maj_d   = tick ? {maj_q[0], sync2_q} : maj_q;
    bit_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & sync2_q) | (maj_q[0] & sync2_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) maj_q <= 2'b11;
    else        maj_q <= maj_d;
  end
`else
  assign bit_val = sync2_q;
`endif

  assign fall = rx_prev_q & ~sync2_q;

  always_comb begin
    par_in = '0;
    par_in[DATA_W-1:0] = shift_q;
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    restart    = 1'b0;
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    if (!rx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d    = ST_START;
            restart    = 1'b1;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
            par_mode_d = parity_e'(parity_mode);
            two_stop_d = two_stop;
          end
        end
        ST_START: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick_cnt_q == MID_LAST) begin
              tick_cnt_d = '0;
              state_d    = bit_val ? ST_IDLE : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick_cnt_q == BIT_LAST) begin
              tick_cnt_d = '0;
              shift_d    = {bit_val, shift_q[DATA_W-1:1]};
              bit_cnt_d  = bit_cnt_q + 1'b1;
              if (bit_cnt_q == DATA_LAST)
                state_d = has_parity(par_mode_q) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick_cnt_q == BIT_LAST) begin
              tick_cnt_d = '0;
              par_err_d  = bit_val ^ par_calc(par_in, par_mode_q);
              state_d    = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick_cnt_q == BIT_LAST) begin
              tick_cnt_d = '0;
              if (!bit_val) stop_err_d = 1'b1;
              if (two_stop_q && !stop_cnt_q) stop_cnt_d = 1'b1;
              else                           state_d    = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign frame_done = (state_q == ST_DONE) && rx_en;
  assign ack        = data_ready_q && rx_if.data_ack;

  // An ack in the completion cycle frees the slot, so the new word wins over overrun.
  always_comb begin
    data_out_d     = data_out_q;
    data_ready_d   = data_ready_q;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    overrun_d      = overrun_q;
    if (ack) begin
      data_ready_d   = 1'b0;
      parity_error_d = 1'b0;
      stop_error_d   = 1'b0;
      overrun_d      = 1'b0;
    end
    if (frame_done) begin
      if (!data_ready_q || ack) begin
        data_out_d     = shift_q;
        data_ready_d   = 1'b1;
        parity_error_d = par_err_q;
        stop_error_d   = stop_err_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_mode_q     <= PAR_NONE;
      two_stop_q     <= 1'b0;
      stop_cnt_q     <= 1'b0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      data_out_q     <= '0;
      data_ready_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_mode_q     <= par_mode_d;
      two_stop_q     <= two_stop_d;
      stop_cnt_q     <= stop_cnt_d;
      par_err_q      <= par_err_d;
      stop_err_q     <= stop_err_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      rx_prev_q      <= rx_prev_d;
      data_out_q     <= data_out_d;
      data_ready_q   <= data_ready_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      overrun_q      <= overrun_d;
    end
  end

  assign busy                = (state_q != ST_IDLE);
  assign rx_if.data_out      = data_out_q;
  assign rx_if.data_ready    = data_ready_q;
  assign rx_if.parity_error  = parity_error_q;
  assign rx_if.stop_error    = stop_error_q;
  assign rx_if.overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param (8N1-style frames, 64 clk/bit)
module tb_uart_rx_param;

  localparam int BIT_CLK = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_en = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  uart_rx_param_if #(.DATA_W(8)) rx_if ();

  uart_rx_param #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .rx          (rx),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .busy        (busy),
    .rx_if       (rx_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cycles(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic par_flip,
                            input logic s1, input logic s2, input logic two);
    logic p;
    p = (pm == 2'd1) ? ^d : (pm == 2'd2) ? ~^d : 1'b0;
    p = p ^ par_flip;
    parity_mode = pm;
    two_stop    = two;
    drive_bit(1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pm == 2'd1 || pm == 2'd2) drive_bit(p);
    drive_bit(s1);
    if (two) drive_bit(s2);
    rx = 1'b1;
    cycles(4);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!rx_if.data_ready && n < 200) begin
      cycles(1);
      n++;
    end
    check(tag, 16'(rx_if.data_ready), 16'd1);
  endtask

  task automatic do_ack();
    rx_if.data_ack = 1'b1;
    cycles(1);
    rx_if.data_ack = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic pe,
                            input logic se, input logic ov);
    check({tag, "_data"}, 16'(rx_if.data_out), 16'(d));
    check({tag, "_perr"}, 16'(rx_if.parity_error), 16'(pe));
    check({tag, "_serr"}, 16'(rx_if.stop_error), 16'(se));
    check({tag, "_ovr"},  16'(rx_if.overrun), 16'(ov));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rx_if.data_ack = 1'b0;
    cycles(5);
    check("rst_busy",  16'(busy), 16'd0);
    check("rst_ready", 16'(rx_if.data_ready), 16'd0);
    check_word("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    rx_en = 1'b1;
    cycles(20);

    send_frame(8'hA5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ready("t1_ready");
    check_word("t1", 8'hA5, 1'b0, 1'b0, 1'b0);
    do_ack();
    check("t1_ack_ready", 16'(rx_if.data_ready), 16'd0);
    check("t1_ack_hold",  16'(rx_if.data_out), 16'h00A5);

    send_frame(8'h07, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_ready("t2_ready");
    check_word("t2", 8'h07, 1'b1, 1'b0, 1'b0);
    do_ack();
    check("t2_ack_perr", 16'(rx_if.parity_error), 16'd0);

    send_frame(8'h07, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ready("t2b_ready");
    check_word("t2b", 8'h07, 1'b0, 1'b0, 1'b0);
    do_ack();

    send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ready("t3_ready");
    check_word("t3", 8'h3C, 1'b0, 1'b1, 1'b0);
    do_ack();

    send_frame(8'h3C, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_ready("t3b_ready");
    check_word("t3b", 8'h3C, 1'b0, 1'b1, 1'b0);
    do_ack();

    send_frame(8'hC3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_ready("t3c_ready");
    check_word("t3c", 8'hC3, 1'b0, 1'b0, 1'b0);
    do_ack();

    rx = 1'b0;
    cycles(15);
    check("t4_busy_start", 16'(busy), 16'd1);
    cycles(5);
    rx = 1'b1;
    cycles(100);
    check("t4_busy_idle", 16'(busy), 16'd0);
    check("t4_ready",     16'(rx_if.data_ready), 16'd0);

    send_frame(8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_ready", 16'(rx_if.data_ready), 16'd1);
    check_word("t5", 8'h11, 1'b0, 1'b0, 1'b1);
    do_ack();
    check("t5_ack_ready", 16'(rx_if.data_ready), 16'd0);
    check("t5_ack_ovr",   16'(rx_if.overrun), 16'd0);

    rx = 1'b0;
    cycles(BIT_CLK);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    cycles(BIT_CLK / 2);
    check("t6_busy_mid", 16'(busy), 16'd1);
    rx_en = 1'b0;
    cycles(1);
    check("t6_busy_drop", 16'(busy), 16'd0);
    rx = 1'b1;
    cycles(10);
    rx_en = 1'b1;
    cycles(100);
    check("t6_no_ready", 16'(rx_if.data_ready), 16'd0);
    send_frame(8'h66, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ready("t6_ready");
    check_word("t6", 8'h66, 1'b0, 1'b0, 1'b0);

    rx = 1'b0;
    cycles(100);
    #3;
    reset = 1'b0;
    #1;
    check("t7_rst_busy",  16'(busy), 16'd0);
    check("t7_rst_ready", 16'(rx_if.data_ready), 16'd0);
    check("t7_rst_data",  16'(rx_if.data_out), 16'd0);
    rx = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
